demux1_2_buf: RTL
=================

// Module: demux1_2_buf
// PURPOSE
//  One-to-two stream demultiplexer. Each word on the input stream goes to output 0 or 1 by a per-word
//  select. Each output has its own 2-entry buffer. Sits downstream of a producer and feeds two
//  consumers, which drain independently. A stalled consumer never blocks words bound for the other.
//  Per-output delivered-word counters support debug.
// PARAMETERS
//  data_width  8   width of data words
//  cnt_width   16  width of per-output delivered-word counters
// PORTS
//  clk         in   1           single clock; all state updates on rising edge
//  rst         in   1           asynchronous, active-high reset
//  d_in        in   data_width  input data word
//  sel         in   1           destination of d_in: 0 -> output 0, 1 -> output 1
//  in_valid    in   1           d_in/sel valid this cycle
//  in_ready    out  1           block can accept d_in to the output named by sel
//  d_out0      out  data_width  output 0 data (head of buffer 0)
//  out_valid0  out  1           buffer 0 non-empty
//  out_ready0  in   1           consumer 0 takes d_out0 this cycle
//  d_out1      out  data_width  output 1 data (head of buffer 1)
//  out_valid1  out  1           buffer 1 non-empty
//  out_ready1  in   1           consumer 1 takes d_out1 this cycle
//  cnt0        out  cnt_width   words delivered on output 0 (out_valid0 & out_ready0)
//  cnt1        out  cnt_width   words delivered on output 1
// BEHAVIOUR
//  - Reset (rst=1, any time, async): both buffers empty, out_valid0/1=0, d_out0/1=0, cnt0/1=0.
//    In-flight words are discarded. The first rising edge after rst falls operates normally.
//  - Buffers: two 2-entry FIFOs, buf0 and buf1, each with an occupancy of 0..2.
//  - in_ready = ~full(buf[sel]). It is combinational from sel and registered occupancy only.
//    It has no path from out_ready0/1.
//  - Accept: at a rising edge where in_valid & in_ready, d_in is written to the tail of buf[sel].
//    in_valid without in_ready leaves state unchanged; the producer holds d_in/sel.
//  - Deliver: at a rising edge where out_validN & out_readyN, the head of bufN is popped and cntN
//    increments by 1.
//  - Latency: a word accepted into an empty buffer at edge k drives d_outN with out_validN=1 in the
//    cycle after edge k. Minimum latency is 1 cycle.
//  - Throughput: a buffer written and read every cycle sustains 1 word/cycle per output.
//  - Simultaneous push+pop, same buffer:
//    - occupancy 1: push and pop both occur; occupancy stays 1 and the new word becomes head.
//    - occupancy 2 (full): in_ready=0, so the push is refused even though a pop occurs that edge;
//      occupancy goes to 1.
//    - occupancy 0: no pop possible; push only.
//  - Simultaneous traffic on both outputs: a push to buf[sel] and pops from buf0 and buf1 may all
//    occur on the same edge.
//  - Ordering: words leave each output in acceptance order. There is no ordering relation between
//    outputs.
//  - Isolation: a full buf1 with out_ready1=0 does not affect in_ready while sel=0, and vice versa.
//  - d_outN is 0 when out_validN=0. It is stable while out_validN=1 and out_readyN=0.
//  - Counters: cntN wraps modulo 2**cnt_width, all-ones -> 0, with no flag.
//  - Changing sel while in_valid=1 and in_ready=0 is legal. in_ready re-evaluates for the new sel.
// TESTING
//  1. Reset, then d_in=8'hA5, sel=0, in_valid=1 for one cycle, out_ready0=1 -> next cycle
//     d_out0=A5, out_valid0=1, out_valid1=0; cnt0=1 after the pop edge.
//  2. out_ready1=0; push 8'h11, 8'h22 with sel=1 -> in_ready=0 for sel=1. Then push 8'h33 with
//     sel=0 -> accepted. Raise out_ready1 -> d_out1 gives 11 then 22, in order.
//  3. Continuous stream 8'h00..8'h0F, sel alternating 0/1, both out_ready=1 -> in_ready stays 1
//     throughout; evens on out0, odds on out1; cnt0=cnt1=8.
//  4. buf0 full and out_ready0=1, with in_valid=1, sel=0 on the same cycle -> push refused;
//     occupancy goes 2 -> 1; in_ready=1 the next cycle.
//  5. Assert rst asynchronously mid-stream, with buf0 holding 2 words and cnt1=5 -> out_valid0/1,
//     d_out0/1, cnt0/1 go to 0 immediately, without waiting for a clock edge.
//  6. cnt_width=4: deliver 17 words on out1 -> cnt1 reads 1 (wrap from 15 to 0, then 1).

Source files
------------

// File: rtl/demux1_2_buf.sv
// One-to-two stream demultiplexer: each input word is steered by sel into one of two
// independent 2-entry FIFOs, each draining to its own consumer with a delivered-word counter.
module demux1_2_buf #(
  parameter int data_width = 8,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] d_in,
  input  logic                  sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [data_width-1:0] d_out0,
  output logic                  out_valid0,
  input  logic                  out_ready0,
  output logic [data_width-1:0] d_out1,
  output logic                  out_valid1,
  input  logic                  out_ready1,
  output logic [cnt_width-1:0]  cnt0,
  output logic [cnt_width-1:0]  cnt1
);

  logic [1:0]                 full;
  logic [1:0]                 vld;
  logic [1:0]                 ordy;
  logic [1:0][data_width-1:0] head;
  logic [1:0][cnt_width-1:0]  cnt;

  assign ordy = {out_ready1, out_ready0};

  // in_ready looks only at the selected buffer's registered occupancy, so a
  // stalled consumer on the other output can never hold off the producer.
  assign in_ready = sel ? ~full[1] : ~full[0];

  for (genvar g = 0; g < 2; g++) begin : g_buf
    localparam logic ID = 1'(g);

    logic [1:0]            occ_q, occ_d;
    logic                  wr_q, wr_d;
    logic                  rd_q, rd_d;
    logic [cnt_width-1:0]  cnt_q, cnt_d;
    logic [data_width-1:0] mem_q [2];
    logic                  push, pop;

    assign push = in_valid & in_ready & (sel == ID);
    assign pop  = (occ_q != 2'd0) & ordy[g];

    always_comb begin
      occ_d = occ_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) wr_d = ~wr_q;
      if (pop) begin
        rd_d  = ~rd_q;
        cnt_d = cnt_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        occ_q <= 2'd0;
        wr_q  <= 1'b0;
        rd_q  <= 1'b0;
        cnt_q <= '0;
      end else begin
        occ_q <= occ_d;
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
      end
    end

    // Storage needs no reset: it is only visible through the valid-gated head.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= d_in;
    end

    assign full[g] = (occ_q == 2'd2);
    assign vld[g]  = (occ_q != 2'd0);
    assign head[g] = vld[g] ? mem_q[rd_q] : '0;
    assign cnt[g]  = cnt_q;
  end

  assign d_out0     = head[0];
  assign d_out1     = head[1];
  assign out_valid0 = vld[0];
  assign out_valid1 = vld[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule
